// File: rtl/hps_key_pio_in_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
// Latency: n/a (signal grouping only).
// Backpressure: none; the slave never stalls (no waitrequest).
interface hps_key_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/hps_key_pio_in.sv
// Key/switch input PIO: sync, optional debounce (KEY_PIO_DEBOUNCE_EN), sticky edge capture, level irq.
// Latency: read data 1 cycle; pin change to edgecapture 3 cycles (3+DEBOUNCE_CYCLES with debounce).
// Backpressure: none; every access completes in one cycle, no waitrequest.
module hps_key_pio_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  hps_key_pio_in_if.slave  avs,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic             rd_en;
  logic             wr_en;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q;
  logic [WIDTH-1:0] rise, fall, edge_hit;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             unused_wd;

  assign rd_en = avs.chipselect &  avs.write_n;
  assign wr_en = avs.chipselect & ~avs.write_n;

  // writedata bits above WIDTH are deliberately ignored
  assign unused_wd = ^avs.writedata;

  // Two-flop synchronizer; idles high so released keys look inactive at reset exit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] deb_q, deb_d;

  // Per-bit stability counter: a new level is accepted only after it has
  // disagreed with the accepted level for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debouncer state; all-ones level so an idle-high key gives no edge at reset exit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign deb = deb_q;
`else
  assign deb = s2_q;
`endif

  // One-cycle history of the accepted level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_dly_q <= '1;
    end else begin
      deb_dly_q <= deb;
    end
  end

  assign rise = deb & ~deb_dly_q;
  assign fall = ~deb & deb_dly_q;

  // Select which transition is recorded as an event
  always_comb begin
    edge_hit = rise | fall;
    if (EDGE_TYPE == 0) begin
      edge_hit = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = fall;
    end
  end

  // Register file next state: mask write, W1C capture where a new edge beats the clear
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && avs.address == 2'd2) begin
      mask_d = avs.writedata[WIDTH-1:0];
    end
    if (wr_en && avs.address == 2'd3) begin
      clr = avs.writedata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~clr) | edge_hit;
  end

  // Read mux, zero-extended; readdata only updates on a read and holds otherwise
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d = '0;
      case (avs.address)
        2'd0:    readdata_d[WIDTH-1:0] = deb;
        2'd2:    readdata_d[WIDTH-1:0] = mask_q;
        2'd3:    readdata_d[WIDTH-1:0] = cap_q;
        default: readdata_d = '0;
      endcase
    end
  end

  // Software-visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_hps_key_pio_in.sv
module tb_hps_key_pio_in;
  localparam int W  = 4;
  localparam int DC = 16;
  localparam int ET = 1;
`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int LAT    = 3 + DC;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '1;
  logic         irq;

  hps_key_pio_in_if bus();

  hps_key_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(ET)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pin as seen two edges later, accepted level (after a run of
  // DC disagreeing cycles when debouncing), previous accepted level, sticky events.
  logic [W-1:0] m_p1, m_p2, m_lvl, m_prev, m_cap, m_mask;
  int           m_run [W];
  logic [31:0]  m_rd;

  always @(posedge clk or negedge reset_n) begin : model
    logic [W-1:0] ev, clr, nl;
    if (!reset_n) begin
      m_p1 = '1; m_p2 = '1; m_lvl = '1; m_prev = '1;
      m_cap = '0; m_mask = '0; m_rd = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      case (ET)
        0:       ev = m_lvl & ~m_prev;
        1:       ev = ~m_lvl & m_prev;
        default: ev = m_lvl ^ m_prev;
      endcase
      clr = '0;
      if (bus.chipselect && bus.write_n) begin
        case (bus.address)
          2'd0:    m_rd = 32'(m_lvl);
          2'd2:    m_rd = 32'(m_mask);
          2'd3:    m_rd = 32'(m_cap);
          default: m_rd = 32'h0;
        endcase
      end
      if (bus.chipselect && !bus.write_n && bus.address == 2'd3) clr = bus.writedata[W-1:0];
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
      m_cap = (m_cap & ~clr) | ev;
      nl = m_lvl;
      for (int i = 0; i < W; i++) begin
        if (m_p2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            nl[i] = m_p2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_prev = m_lvl;
      m_p2 = m_p1;
      m_p1 = in_port;
      m_lvl = DEB_ON ? nl : m_p2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    check("model_readdata", bus.readdata, m_rd);
    check("model_irq", 32'(irq), 32'(|(m_cap & m_mask)));
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'h0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    tick();
    d = bus.readdata;
    bus_idle();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] exp;
    int          op;
    bus_idle();
    in_port = '1;
    reset_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick(); tick();
    bus_rd(2'd0, r);
    check("rd_data_idle", r, 32'h0000000F);

    // Press on bit 0 with mask bit 0: irq exactly at the sync(+debounce) latency
    bus_wr(2'd2, 32'h1);
    in_port[0] = 1'b0;
    repeat (LAT - 1) tick();
    check("press_irq_early", 32'(irq), 32'h0);
    tick();
    check("press_irq", 32'(irq), 32'h1);
    bus_rd(2'd3, r);
    check("press_cap", r, 32'h1);
    in_port[0] = 1'b1;
    repeat (LAT + 2) tick();
    bus_rd(2'd3, r);
    check("release_no_capture", r, 32'h1);
    bus_wr(2'd3, 32'hF);
    check("clear_irq", 32'(irq), 32'h0);

    // Short glitch on bit 1: rejected only when debouncing
    in_port[1] = 1'b0;
    repeat (10) tick();
    in_port[1] = 1'b1;
    repeat (LAT + 4) tick();
    bus_rd(2'd0, r);
    check("glitch_data", r, 32'hF);
    bus_rd(2'd3, r);
    exp = DEB_ON ? 32'h0 : 32'h2;
    check("glitch_cap", r, exp);
    check("glitch_irq", 32'(irq), 32'h0);
    bus_wr(2'd3, 32'hF);

    // Edge on bit 2 lands in the same cycle as its W1C clear: set wins
    bus_wr(2'd2, 32'hF);
    in_port[2] = 1'b0;
    repeat (LAT - 1) tick();
    bus_wr(2'd3, 32'h4);
    check("race_irq", 32'(irq), 32'h1);
    bus_rd(2'd3, r);
    check("race_cap", r, 32'h4);
    bus_wr(2'd3, 32'h4);
    check("race_clear_irq", 32'(irq), 32'h0);
    bus_rd(2'd3, r);
    check("race_clear_cap", r, 32'h0);
    in_port[2] = 1'b1;
    repeat (LAT + 2) tick();

    // Mask gating of a capture on bit 3, reserved address, ignored writes
    bus_wr(2'd2, 32'h0);
    in_port[3] = 1'b0;
    repeat (LAT + 2) tick();
    check("masked_irq", 32'(irq), 32'h0);
    bus_rd(2'd3, r);
    check("masked_cap", r, 32'h8);
    bus_wr(2'd2, 32'hFFFF_FFF8);
    check("unmask_irq", 32'(irq), 32'h1);
    bus_rd(2'd1, r);
    check("reserved_rd", r, 32'h0);
    bus_rd(2'd2, r);
    check("mask_rd_zext", r, 32'h8);
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'hF);
    bus_rd(2'd0, r);
    check("data_after_ro_writes", r, 32'h7);
    in_port[3] = 1'b1;
    repeat (LAT + 2) tick();
    bus_wr(2'd3, 32'hF);

    // Reset mid-count with the key held across release
    in_port[0] = 1'b0;
    repeat (LAT / 2) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_readdata", bus.readdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    tick();
    reset_n = 1'b1;
    bus_wr(2'd2, 32'h1);
    repeat (LAT - 2) tick();
    check("postrst_irq_early", 32'(irq), 32'h0);
    tick();
    check("postrst_irq", 32'(irq), 32'h1);
    in_port[0] = 1'b1;
    repeat (LAT + 2) tick();
    bus_wr(2'd3, 32'hF);

    // Randomized pins and bus traffic against the model
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, DEB_ON ? 24 : 3) == 0) in_port = W'($urandom);
      op = int'($urandom_range(0, 3));
      if (op == 1) begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = 2'($urandom);
      end else if (op == 2) begin
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'($urandom);
        bus.writedata  = $urandom;
      end
      tick();
      bus_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
